// File: rtl/mine_placer_pkg.sv
// Shared definitions for the minefield slot placer.
//   state_t            : scan controller states
//   DEF_*              : default slot geometry (pixel origin / pitch)
//   LFSR_TAP_MASK      : Fibonacci taps 16,14,13,11 as a bit mask
//   LFSR_DEFAULT_SEED  : value loaded in place of an all-zero seed
//   lfsr_next()        : one LFSR step
package mine_placer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [10:0] DEF_X_ORIGIN = 11'h70;
  localparam logic [10:0] DEF_X_PITCH  = 11'h30;
  localparam logic [10:0] DEF_Y_ORIGIN = 11'h80;
  localparam logic [10:0] DEF_Y_PITCH  = 11'h60;

  // Bits 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// 16-bit Fibonacci LFSR used for random slot thinning.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   load       : load seed (an all-zero seed is replaced by LFSR_DEFAULT_SEED)
//   step       : advance one step (load has priority)
//   seed       : seed value
//   state      : current LFSR contents
module mine_lfsr
  import mine_placer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else if (load) begin
      // An all-zero LFSR would lock up, so zero seeds get a fixed substitute.
      lfsr_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/mine_field_placer.sv
// Minefield slot placer: on start, scans a ROWS x COLS grid in row-major
// order and emits one (row, col, pixel_x, pixel_y) record per selected cell
// over a valid/ready stream, then pulses done.
// Build option: define MINE_PLACER_RANDOM_EN to thin the selection with a
// seeded LFSR (cell kept when its mask bit is set and lfsr[7:0] < DENSITY).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a scan (ignored unless idle)
//   cell_mask    : per-cell enables, bit row*COLS+col, latched on start
//   seed         : LFSR seed, latched on start (random build only)
//   out_valid    : record valid; out_ready : consumer accepts record
//   out_row/col  : slot coordinates; pixel_x/pixel_y : slot pixel position
//   busy         : scan in progress; done : one-cycle end-of-scan pulse
//   mine_count   : records handed off in the last or current scan
module mine_field_placer
  import mine_placer_pkg::*;
#(
  parameter int          ROWS     = 3,
  parameter int          COLS     = 4,
  parameter logic [10:0] X_ORIGIN = DEF_X_ORIGIN,
  parameter logic [10:0] X_PITCH  = DEF_X_PITCH,
  parameter logic [10:0] Y_ORIGIN = DEF_Y_ORIGIN,
  parameter logic [10:0] Y_PITCH  = DEF_Y_PITCH,
  parameter logic [7:0]  DENSITY  = 8'h60,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int MCW = $clog2(ROWS * COLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   cell_mask,
  input  logic [15:0]            seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic [10:0]            pixel_x,
  output logic [10:0]            pixel_y,
  output logic                   busy,
  output logic                   done,
  output logic [MCW-1:0]         mine_count
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  // Origin + pitch*index, all at 11 bits so the result wraps mod 2048.
  function automatic logic [10:0] pixel_coord(input logic [10:0] origin,
                                              input logic [10:0] pitch,
                                              input logic [10:0] idx);
    return origin + pitch * idx;
  endfunction

  state_t             state_q, state_d;
  logic [NCELLS-1:0]  mask_q;
  logic [RW-1:0]      ptr_row;
  logic [CW-1:0]      ptr_col;
  logic [IW-1:0]      ptr_idx;
  logic               cell_sel;
  logic               is_last;
  logic               accept_start;
  logic               advance;
  logic               capture;
  logic               handshake;

  assign is_last = (ptr_row == RW'(ROWS - 1)) && (ptr_col == CW'(COLS - 1));

`ifdef MINE_PLACER_RANDOM_EN
  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;

  // The LFSR steps with the cell pointer so each cell sees its own draw.
  mine_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_start),
    .step  (advance),
    .seed  (seed),
    .state (lfsr_state)
  );

  assign cell_sel       = mask_q[ptr_idx] && (lfsr_state[7:0] < DENSITY);
  assign unused_lfsr_hi = ^lfsr_state[15:8];
`else
  logic unused_cfg;

  assign cell_sel   = mask_q[ptr_idx];
  assign unused_cfg = ^{seed, DENSITY};
`endif

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    advance      = 1'b0;
    capture      = 1'b0;
    handshake    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (cell_sel) begin
          capture = 1'b1;
          state_d = EMIT;
        end else begin
          advance = 1'b1;
          if (is_last) state_d = DONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          handshake = 1'b1;
          advance   = 1'b1;
          state_d   = is_last ? DONE : SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Pointer, latched mask, output record and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      ptr_row    <= '0;
      ptr_col    <= '0;
      ptr_idx    <= '0;
      out_row    <= '0;
      out_col    <= '0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      mine_count <= '0;
    end else begin
      if (accept_start) begin
        mask_q     <= cell_mask;
        ptr_row    <= '0;
        ptr_col    <= '0;
        ptr_idx    <= '0;
        mine_count <= '0;
      end
      if (advance) begin
        if (ptr_col == CW'(COLS - 1)) begin
          ptr_col <= '0;
          ptr_row <= (ptr_row == RW'(ROWS - 1)) ? '0 : ptr_row + RW'(1);
        end else begin
          ptr_col <= ptr_col + CW'(1);
        end
        ptr_idx <= is_last ? '0 : ptr_idx + IW'(1);
      end
      // Record is only written on entry to EMIT, so it holds under backpressure.
      if (capture) begin
        out_row <= ptr_row;
        out_col <= ptr_col;
        pixel_x <= pixel_coord(X_ORIGIN, X_PITCH, 11'(ptr_row));
        pixel_y <= pixel_coord(Y_ORIGIN, Y_PITCH, 11'(ptr_col));
      end
      if (handshake) mine_count <= mine_count + MCW'(1);
    end
  end

endmodule

// File: doc/mine_field_placer.md
Name: mine_field_placer

Overview:
Sequential, parametrised mine-slot generator for the VGA minefield. On a start pulse it scans a ROWS x COLS grid in row-major order and selects slots from a cell mask. It emits one (row, col, pixel_x, pixel_y) record per selected slot over a valid/ready stream to the object-drawing logic. It pulses done and reports the placed-mine count when the scan finishes.

Parameters:
ROWS, 3, grid rows (>=1)
COLS, 4, grid columns (>=1)
X_ORIGIN, 11'h70, pixel_x of row 0
X_PITCH, 11'h30, pixel_x step per row
Y_ORIGIN, 11'h80, pixel_y of col 0
Y_PITCH, 11'h60, pixel_y step per col
DENSITY, 8'h60, random-mode threshold (slot kept when lfsr[7:0] < DENSITY)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
start  in  1  one-cycle request to begin a scan; ignored unless idle
cell_mask  in  ROWS*COLS  slot enables, bit index = row*COLS+col; latched on accepted start
seed  in  16  LFSR seed, latched on accepted start (used only with the optional feature)
out_valid  out  1  record valid
out_ready  in  1  consumer accepts record
out_row  out  RW=max(1,$clog2(ROWS))  slot row
out_col  out  CW=max(1,$clog2(COLS))  slot column
pixel_x  out  11  X_ORIGIN + X_PITCH*row, mod 2048
pixel_y  out  11  Y_ORIGIN + Y_PITCH*col, mod 2048
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of scan
mine_count  out  $clog2(ROWS*COLS+1)  records handed off in the last or current scan

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, done, busy, out_row, out_col, pixel_x, pixel_y, mine_count = 0; latched mask = 0; LFSR = 0.
- States:
  - IDLE -> SCAN on start. Latch cell_mask and seed; clear mine_count; cell pointer = (0,0).
  - SCAN evaluates the current cell each cycle.
    - Selected: register row, col, pixel_x and pixel_y; go to EMIT. out_valid rises the next cycle.
    - Not selected: advance the pointer. A cell that is last and not selected goes to DONE.
  - EMIT holds out_valid=1 with stable data until out_ready=1.
    - On the handshake cycle: mine_count++, clear out_valid, advance the pointer.
    - Then go to DONE if that was the last cell, else SCAN.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start at cycle t gives the first possible out_valid at t+2. Each skipped cell costs 1 cycle. Each emitted cell costs at least 2 cycles (SCAN + EMIT).
- Pointer order is row-major: col increments, wraps at COLS-1 to 0 with row++. The last cell is (ROWS-1, COLS-1).
- Arithmetic: products computed at 11 bits and truncated; no saturation.
- start while busy: ignored, with no effect on the mask or seed.
- out_ready while out_valid=0: ignored.
- Output data must not change while out_valid=1 and out_ready=0.
- Mask all zero: scan takes ROWS*COLS cycles, then done with mine_count=0.
- mine_count holds its value in IDLE until the next accepted start.
- Reset mid-scan: immediate return to IDLE with reset values; no done pulse.

Optional Feature:
MINE_PLACER_RANDOM_EN
- Defined:
  - A cell is selected when its mask bit = 1 AND lfsr[7:0] < DENSITY.
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11) loads seed on start; seed=0 loads 16'hACE1.
  - The LFSR steps once per pointer advance.
- Undefined: selection = mask bit only; seed is ignored; no LFSR logic is synthesised.

Decomposition:
- mine_placer_pkg: state enum (IDLE, SCAN, EMIT, DONE); default geometry constants (11'h70, 11'h30, 11'h80, 11'h60); LFSR tap mask; LFSR_DEFAULT_SEED=16'hACE1.
- One sub-module: mine_lfsr (16-bit LFSR with load/step/seed-zero substitution), instantiated only under MINE_PLACER_RANDOM_EN.

Test Plan:
- Default params, mask=12'hFFF, out_ready=1, start -> 12 records in order.
  - First record: (0,0) x=0x070 y=0x080.
  - Last record: (2,3) x=0x0D0 y=0x1A0.
  - done pulses once; mine_count=12.
- mask=12'h000, start at t -> no out_valid; done at t+13; mine_count=0; busy high t+1..t+13.
- mask bit 5 only, out_ready low for 4 cycles after out_valid:
  - record (1,1) x=0x0A0 y=0x0E0 held stable for all 5 valid cycles.
  - mine_count=1.
- start pulsed again mid-scan with a different mask -> ignored; the original record sequence completes unchanged.
- rst_n asserted during EMIT -> out_valid, busy, mine_count = 0 immediately; no done pulse; a new start then runs a full scan.
- With MINE_PLACER_RANDOM_EN, seed=0, DENSITY=8'hFF, mask=12'hFFF:
  - compare record order to the bench LFSR model seeded 16'hACE1.
  - rerunning with the same seed gives an identical sequence.
